qam_symbol_scheduler: RTL
=========================

Name: qam_symbol_scheduler

Overview:
- Sits between Streamer (4-bit QAM block source) and QAM (modulator datapath).
- Buffers incoming QAM blocks in a small FIFO and releases them to QAM at a register-programmed symbol rate.
- Organises output into bursts: preamble, payload, then a silent guard interval.
- Reports state, FIFO level and underrun/overflow statistics to the Registers block.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 4.
- START_THRESHOLD, 8, FIFO level required before a burst starts; must be 1..FIFO_DEPTH.
- GUARD_TICKS, 4, number of silent symbol ticks after a burst.
- PREAMBLE_A, 4'h0, preamble symbol emitted on even indices.
- PREAMBLE_B, 4'hF, preamble symbol emitted on odd indices.

Ports:
- ipClk  in  1  system clock.
- ipReset  in  1  asynchronous reset, active-low.
- ipEnable  in  1  burst enable, from WrRegisters.
- ipSymbolPeriod  in  16  clocks per symbol; 0 is treated as 1.
- ipPreambleLen  in  8  preamble symbols per burst; 0 means no preamble.
- ipQAMBlock  in  4  input symbol from Streamer.
- ipQAMBlockValid  in  1  one-cycle strobe qualifying ipQAMBlock.
- opQAMBlock  out  4  symbol to QAM.
- opQAMBlockValid  out  1  one-cycle strobe per emitted symbol.
- opState  out  2  0=IDLE, 1=PREAMBLE, 2=PAYLOAD, 3=GUARD.
- opFIFOLevel  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- opUnderrunCount  out  16  saturating count of underrun events.
- opOverflowCount  out  16  saturating count of dropped input symbols.
- opBurstCount  out  16  wrapping count of completed bursts.

Behaviour:
- Reset (ipReset low, asynchronous): state IDLE; FIFO empty; all counters 0; opQAMBlock=0; opQAMBlockValid=0; tick counter 0.
- Reset asserted mid-burst aborts the burst immediately. No valid strobe is emitted after reset asserts.
- FIFO push:
  - Every cycle with ipQAMBlockValid=1, regardless of state.
  - If full with no pop in the same cycle: symbol dropped and opOverflowCount increments.
  - If full with a pop in the same cycle: push accepted and level unchanged.
- Period latch and tick:
  - Period P=max(ipSymbolPeriod,1) is latched on the IDLE->PREAMBLE or IDLE->PAYLOAD transition. Changes to ipSymbolPeriod mid-burst are ignored.
  - The tick counter runs only outside IDLE. It counts 0..P-1, and tick=1 when the count equals P-1.
  - The first tick occurs P cycles after leaving IDLE.
- IDLE:
  - Exit when ipEnable=1 and level>=START_THRESHOLD.
  - ipPreambleLen (latched) nonzero: go to PREAMBLE. Zero: go to PAYLOAD.
  - opQAMBlockValid=0 throughout.
- PREAMBLE:
  - On each tick, emit PREAMBLE_A or PREAMBLE_B by index parity, starting with A at index 0.
  - After the latched length of symbols, go to PAYLOAD.
- PAYLOAD, on each tick:
  - FIFO non-empty: pop and emit the head symbol. Output is registered, so the strobe appears the cycle after the tick.
  - FIFO empty: no strobe, opUnderrunCount increments, go to GUARD.
- ipEnable=0 during PREAMBLE or PAYLOAD:
  - At the next tick, go to GUARD without emitting.
  - The FIFO contents are kept.
- GUARD:
  - Count GUARD_TICKS ticks with no strobes.
  - Then go to IDLE and increment opBurstCount.
- Strobe rules: opQAMBlockValid is high for exactly one clock per emitted symbol, and opQAMBlock holds its value between strobes.
- Counter arithmetic: opUnderrunCount and opOverflowCount saturate at 16'hFFFF. opBurstCount wraps.

Optional Feature:
- Macro SCHED_STATS_EN.
  - Defined: the three statistics counters are implemented as described.
  - Undefined: opUnderrunCount, opOverflowCount and opBurstCount are tied to 0 and no counter flops are synthesised. All other behaviour is identical.

Decomposition:
- Shared package (Structures):
  - sched_state_t enum (IDLE, PREAMBLE, PAYLOAD, GUARD, 2-bit encoding as opState).
  - QAM_SYMBOL_W=4.
  - The preamble default constants.
  - A packed SCHED_STATUS struct grouping state, level and counters for RD_REGISTERS.
- Sub-module symbol_fifo:
  - Synchronous single-clock FIFO with width and depth parameters.
  - Provides push, pop, full, empty and level.
  - Simultaneous push and pop when full is legal.

Test Plan:
- P=4, preamble=2, 10 symbols pushed, enable=1: burst starts at level 8. Strobes every 4 clocks carry 0,F, then the 10 data symbols in order. One underrun follows, then 4 silent ticks, then IDLE with opBurstCount=1.
- ipSymbolPeriod=0, preamble=0, 8 symbols pushed: 8 strobes on consecutive clocks, then underrun=1.
- 20 symbols pushed back-to-back while IDLE with enable=0: level=16 and opOverflowCount=4.
- Symbol pushed on the same clock as a pop with a full FIFO: level stays 16 and overflow is unchanged.
- ipEnable dropped mid-payload with 5 symbols left: next tick goes to GUARD with no strobe, level stays 5, and underrun is unchanged.
- ipReset pulsed low mid-preamble: opState=0, opQAMBlockValid=0 and all counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/qam_symbol_scheduler_pkg.sv
// Shared types and constants for the QAM symbol scheduler and the status
// view exported to the register read path.
package qam_symbol_scheduler_pkg;

  localparam int QAM_SYMBOL_W   = 4;
  localparam int STATUS_LEVEL_W = 8;

  localparam logic [QAM_SYMBOL_W-1:0] PREAMBLE_A_DEF = 4'h0;
  localparam logic [QAM_SYMBOL_W-1:0] PREAMBLE_B_DEF = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    GUARD    = 2'd3
  } sched_state_t;

  typedef struct packed {
    sched_state_t                state;
    logic [STATUS_LEVEL_W-1:0]   level;
    logic [15:0]                 underrun_count;
    logic [15:0]                 overflow_count;
    logic [15:0]                 burst_count;
  } sched_status_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

  function automatic sched_status_t pack_status(
    input sched_state_t              state,
    input logic [STATUS_LEVEL_W-1:0] level,
    input logic [15:0]               underrun_count,
    input logic [15:0]               overflow_count,
    input logic [15:0]               burst_count
  );
    sched_status_t status;
    status.state          = state;
    status.level          = level;
    status.underrun_count = underrun_count;
    status.overflow_count = overflow_count;
    status.burst_count    = burst_count;
    return status;
  endfunction

endpackage

// File: rtl/qam_symbol_scheduler_symbol_fifo.sv
// Single-clock FIFO buffering QAM symbols; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module symbol_fifo
  import qam_symbol_scheduler_pkg::*;
#(
  parameter  int WIDTH = QAM_SYMBOL_W,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign full      = (count_r == LW'(DEPTH));
  assign empty     = (count_r == {LW{1'b0}});
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign level     = count_r;

  // Storage array; contents need no reset because the count qualifies them.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/qam_symbol_scheduler.sv
// Buffers Streamer symbols and releases them to QAM in preamble/payload/guard
// bursts at a programmable symbol rate. Statistics counters need SCHED_STATS_EN.
module qam_symbol_scheduler
  import qam_symbol_scheduler_pkg::*;
#(
  parameter  int                      FIFO_DEPTH      = 16,
  parameter  int                      START_THRESHOLD = 8,
  parameter  int                      GUARD_TICKS     = 4,
  parameter  logic [QAM_SYMBOL_W-1:0] PREAMBLE_A      = PREAMBLE_A_DEF,
  parameter  logic [QAM_SYMBOL_W-1:0] PREAMBLE_B      = PREAMBLE_B_DEF,
  localparam int                      LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  logic                    ipEnable,
  input  logic [15:0]             ipSymbolPeriod,
  input  logic [7:0]              ipPreambleLen,
  input  logic [QAM_SYMBOL_W-1:0] ipQAMBlock,
  input  logic                    ipQAMBlockValid,
  output logic [QAM_SYMBOL_W-1:0] opQAMBlock,
  output logic                    opQAMBlockValid,
  output logic [1:0]              opState,
  output logic [LVL_W-1:0]        opFIFOLevel,
  output logic [15:0]             opUnderrunCount,
  output logic [15:0]             opOverflowCount,
  output logic [15:0]             opBurstCount
);

  localparam int          GUARD_N    = (GUARD_TICKS < 1) ? 1 : GUARD_TICKS;
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_N - 1);

  sched_state_t            state_r;
  sched_state_t            state_next_s;
  logic [15:0]             period_r;
  logic [15:0]             tick_cnt_r;
  logic [7:0]              pre_len_r;
  logic [7:0]              pre_idx_r;
  logic [15:0]             guard_cnt_r;
  logic [QAM_SYMBOL_W-1:0] out_sym_r;
  logic                    out_valid_r;

  logic                    tick_s;
  logic                    ready_s;
  logic                    start_s;
  logic                    emit_s;
  logic [QAM_SYMBOL_W-1:0] emit_sym_s;
  logic                    pop_s;

  logic [QAM_SYMBOL_W-1:0] fifo_head_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [LVL_W-1:0]        fifo_level_s;

  symbol_fifo #(
    .WIDTH (QAM_SYMBOL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ipClk),
    .rst_n     (ipReset),
    .push      (ipQAMBlockValid),
    .push_data (ipQAMBlock),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level_s)
  );

  // A full FIFO always meets the threshold, whatever the depth/threshold pair.
  assign ready_s = fifo_full_s || (fifo_level_s >= LVL_W'(START_THRESHOLD));
  assign tick_s  = (state_r != IDLE) && (tick_cnt_r == (period_r - 16'd1));

  // Burst state register.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-tick emit/pop decisions.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    emit_s       = 1'b0;
    emit_sym_s   = {QAM_SYMBOL_W{1'b0}};
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (ipEnable && ready_s) begin
          start_s = 1'b1;
          if (ipPreambleLen != 8'd0) begin
            state_next_s = PREAMBLE;
          end else begin
            state_next_s = PAYLOAD;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      PREAMBLE: begin
        if (!tick_s) begin
          state_next_s = PREAMBLE;
        end else if (!ipEnable) begin
          state_next_s = GUARD;
        end else begin
          emit_s     = 1'b1;
          emit_sym_s = pre_idx_r[0] ? PREAMBLE_B : PREAMBLE_A;
          if (pre_idx_r == (pre_len_r - 8'd1)) begin
            state_next_s = PAYLOAD;
          end else begin
            state_next_s = PREAMBLE;
          end
        end
      end
      PAYLOAD: begin
        if (!tick_s) begin
          state_next_s = PAYLOAD;
        end else if (!ipEnable || fifo_empty_s) begin
          state_next_s = GUARD;
        end else begin
          pop_s      = 1'b1;
          emit_s     = 1'b1;
          emit_sym_s = fifo_head_s;
        end
      end
      GUARD: begin
        if (tick_s && (guard_cnt_r == GUARD_LAST)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = GUARD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Burst parameters latched at start, symbol-rate divider and burst indices.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      period_r    <= 16'd1;
      pre_len_r   <= 8'd0;
      tick_cnt_r  <= 16'd0;
      pre_idx_r   <= 8'd0;
      guard_cnt_r <= 16'd0;
    end else begin
      if (start_s) begin
        period_r  <= (ipSymbolPeriod == 16'd0) ? 16'd1 : ipSymbolPeriod;
        pre_len_r <= ipPreambleLen;
      end else begin
        period_r  <= period_r;
        pre_len_r <= pre_len_r;
      end
      if ((state_r == IDLE) || tick_s) begin
        tick_cnt_r <= 16'd0;
      end else begin
        tick_cnt_r <= tick_cnt_r + 16'd1;
      end
      if (start_s) begin
        pre_idx_r <= 8'd0;
      end else if (emit_s && (state_r == PREAMBLE)) begin
        pre_idx_r <= pre_idx_r + 8'd1;
      end else begin
        pre_idx_r <= pre_idx_r;
      end
      if (state_r != GUARD) begin
        guard_cnt_r <= 16'd0;
      end else if (tick_s) begin
        guard_cnt_r <= guard_cnt_r + 16'd1;
      end else begin
        guard_cnt_r <= guard_cnt_r;
      end
    end
  end

  // Registered symbol output; the symbol holds between strobes.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      out_valid_r <= 1'b0;
      out_sym_r   <= {QAM_SYMBOL_W{1'b0}};
    end else begin
      out_valid_r <= emit_s;
      if (emit_s) begin
        out_sym_r <= emit_sym_s;
      end else begin
        out_sym_r <= out_sym_r;
      end
    end
  end

  assign opQAMBlock      = out_sym_r;
  assign opQAMBlockValid = out_valid_r;
  assign opState         = state_r;
  assign opFIFOLevel     = fifo_level_s;

`ifdef SCHED_STATS_EN
  logic [15:0] underrun_cnt_r;
  logic [15:0] overflow_cnt_r;
  logic [15:0] burst_cnt_r;
  logic        drop_s;
  logic        underrun_s;
  logic        burst_done_s;

  assign drop_s       = ipQAMBlockValid && fifo_full_s && !pop_s;
  assign underrun_s   = (state_r == PAYLOAD) && tick_s && ipEnable && fifo_empty_s;
  assign burst_done_s = (state_r == GUARD) && (state_next_s == IDLE);

  // Underrun/overflow saturate; the burst count wraps.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      underrun_cnt_r <= 16'd0;
      overflow_cnt_r <= 16'd0;
      burst_cnt_r    <= 16'd0;
    end else begin
      underrun_cnt_r <= underrun_s ? sat_inc16(underrun_cnt_r) : underrun_cnt_r;
      overflow_cnt_r <= drop_s ? sat_inc16(overflow_cnt_r) : overflow_cnt_r;
      burst_cnt_r    <= burst_done_s ? (burst_cnt_r + 16'd1) : burst_cnt_r;
    end
  end

  assign opUnderrunCount = underrun_cnt_r;
  assign opOverflowCount = overflow_cnt_r;
  assign opBurstCount    = burst_cnt_r;
`else
  assign opUnderrunCount = 16'd0;
  assign opOverflowCount = 16'd0;
  assign opBurstCount    = 16'd0;
`endif

endmodule
